uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line rate in bits/s; bit period P = CLOCK_FREQ / BAUD_RATE cycles, integer-truncated.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..8, data bits per frame.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2, transmit FIFO entries.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data_in, input, 8, byte to transmit; bits above DATA_BITS-1 ignored.
REQ-008 SHALL have port data_in_valid, input, 1, producer offers data_in.
REQ-009 SHALL have port data_in_ready, output, 1, FIFO can accept a byte.
REQ-010 SHALL have port parity_mode, input, 2, 00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 SHALL have port two_stop, input, 1, 1 = two stop bits, 0 = one.
REQ-012 SHALL have port serial_out, output, 1, UART line, idle high.
REQ-013 SHALL have port tx_busy, output, 1, high while a frame is on the line.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, entries currently queued.

Function
REQ-015 Push: data_in SHALL be written when data_in_valid && data_in_ready at a clock edge.
REQ-016 data_in_ready SHALL equal (fifo_count != FIFO_DEPTH), independent of a same-cycle pop; a full FIFO refuses a push even while popping.
REQ-017 Pop: when state IDLE and fifo_count != 0, the head SHALL be popped into the shift register and state -> START on the same edge.
REQ-018 parity_mode and two_stop SHALL be captured at the pop edge and held constant for that frame; mid-frame changes affect only later frames.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP; an FSM in any other encoding SHALL go to IDLE.
REQ-020 Frame order: START (line 0) -> DATA (DATA_BITS bits, LSB first) -> PARITY (only if mode 01/10) -> STOP (line 1, one or two bit periods) -> IDLE.
REQ-021 Each bit SHALL be driven for exactly P cycles, measured by a bit-period counter cleared at the pop edge and at each bit boundary.
REQ-022 serial_out SHALL be registered; it goes low on the cycle following the pop edge.
REQ-023 Even parity bit SHALL be XOR of the DATA_BITS data bits; odd parity SHALL be its inverse.
REQ-024 Frame length SHALL be (1 + DATA_BITS + parity? + stop bits) * P cycles.
REQ-025 Back-to-back: if FIFO non-empty when STOP ends, next pop SHALL occur on the IDLE cycle following STOP, giving exactly 1 cycle of idle-high between frames.
REQ-026 tx_busy SHALL be high in every non-IDLE state and low in IDLE.
REQ-027 fifo_count SHALL increment on push only, decrement on pop only, and remain unchanged on simultaneous push and pop.
REQ-028 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 On reset high at a clock edge: state IDLE, fifo_count 0, pointers 0, serial_out 1, tx_busy 0, data_in_ready 1, bit counter 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard queued bytes; serial_out SHALL be 1 the next cycle.
REQ-031 Reset SHALL take priority over simultaneous push or pop; neither takes effect.

Verification
(bench uses CLOCK_FREQ=1000, BAUD_RATE=100, so P=10; FIFO_DEPTH=4)
REQ-032 Push 0xA5, DATA_BITS=8, mode 00, two_stop 0 -> line 0,1,0,1,0,0,1,0,1,1 each 10 cycles; tx_busy high 100 cycles.
REQ-033 Push 0x03, DATA_BITS=7, mode 10, two_stop 1 -> data 1,1,0,0,0,0,0, parity 1, two stop bits; frame 110 cycles.
REQ-034 Push 6 bytes on consecutive cycles while idle -> pushes 1-5 accepted (one pops immediately), 6th refused with data_in_ready 0; all 5 frames sent in order, 1 idle cycle between.
REQ-035 Simultaneous push and pop at fifo_count 2 -> fifo_count stays 2; pointers wrap after 4 pushes with data intact.
REQ-036 Reset at cycle 35 of a frame with 2 queued -> serial_out 1 next cycle, fifo_count 0, tx_busy 0, no further frames.
REQ-037 Change parity_mode 00->01 mid-frame -> current frame has no parity bit; next frame carries even parity.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small synchronous FIFO.
// Frame: start, DATA_BITS data (LSB first), optional parity, one or two stop bits.
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          serial_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int P  = CLOCK_FREQ / BAUD_RATE;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (P > 1) ? $clog2(P) : 1;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BIT_LAST  = BW'(P - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [BW-1:0]          bit_cnt;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   stop_idx;
    logic                   par_en;
    logic                   par_bit;
    logic                   two_stop_r;

    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic [DATA_BITS-1:0]   head;

    always_comb begin
        data_in_ready = (fifo_count != FULL);
        push          = data_in_valid && data_in_ready;
        pop           = (state == IDLE) && (fifo_count != '0);
        bit_end       = (bit_cnt == BIT_LAST);
        head          = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= data_in[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame settings are latched at the pop edge so mid-frame input changes only affect later frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            stop_idx   <= 1'b0;
            par_en     <= 1'b0;
            par_bit    <= 1'b0;
            two_stop_r <= 1'b0;
        end else begin
            if (state != IDLE) begin
                bit_cnt <= bit_end ? '0 : bit_cnt + BW'(1);
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift      <= head;
                        par_en     <= parity_mode[0] ^ parity_mode[1];
                        par_bit    <= (^head) ^ parity_mode[1];
                        two_stop_r <= two_stop;
                        bit_cnt    <= '0;
                        serial_out <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_out <= shift[0];
                        shift      <= shift >> 1;
                        bit_idx    <= '0;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == DATA_LAST) begin
                            stop_idx <= 1'b0;
                            if (par_en) begin
                                serial_out <= par_bit;
                                state      <= PARITY;
                            end else begin
                                serial_out <= 1'b1;
                                state      <= STOP;
                            end
                        end else begin
                            serial_out <= shift[0];
                            shift      <= shift >> 1;
                            bit_idx    <= bit_idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        serial_out <= 1'b1;
                        stop_idx   <= 1'b0;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (two_stop_r && !stop_idx) begin
                            stop_idx <= 1'b1;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    tx_busy    <= 1'b0;
                    bit_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: P = 10 cycles, 4-entry FIFO, 8-bit and 7-bit instances.
module tb_uart_tx_fifo;

    localparam int P = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid8, valid7;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       ready8, ready7;
    logic       so8, so7;
    logic       busy8, busy7;
    logic [2:0] count8, count7;

    int checks = 0;
    int errors = 0;

    logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] wrap_bytes [5] = '{8'hC3, 8'h81, 8'h7E, 8'h0F, 8'hF0};

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100),
        .DATA_BITS  (8),
        .FIFO_DEPTH (4)
    ) dut8 (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (valid8),
        .data_in_ready (ready8),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .serial_out    (so8),
        .tx_busy       (busy8),
        .fifo_count    (count8)
    );

    uart_tx_fifo #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100),
        .DATA_BITS  (7),
        .FIFO_DEPTH (4)
    ) dut7 (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_valid (valid7),
        .data_in_ready (ready7),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .serial_out    (so7),
        .tx_busy       (busy7),
        .fifo_count    (count7)
    );

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic cur_line(input int which);
        return (which != 0) ? so7 : so8;
    endfunction

    function automatic logic cur_busy(input int which);
        return (which != 0) ? busy7 : busy8;
    endfunction

    // bits[i] is the i-th bit on the line, starting with the start bit; each must last exactly P cycles.
    task automatic rx_frame(input string tag, input int which, input logic [15:0] bits,
                            input int n, output int gap);
        int good [16];
        int busy_cnt;
        for (int b = 0; b < 16; b++) good[b] = 0;
        busy_cnt = 0;
        gap = 0;
        while (cur_line(which) !== 1'b0 && gap < 1000) begin
            gap++;
            @(negedge clk);
        end
        if (gap >= 1000) begin
            check({tag, " start_timeout"}, 1, 0);
            return;
        end
        for (int i = 0; i < n * P; i++) begin
            if (i > 0) @(negedge clk);
            if (cur_line(which) === bits[i / P]) good[i / P]++;
            if (cur_busy(which) === 1'b1) busy_cnt++;
        end
        for (int b = 0; b < n; b++) begin
            check($sformatf("%s bit%0d_cycles", tag, b), good[b], P);
        end
        check({tag, " busy_cycles"}, busy_cnt, n * P);
        @(negedge clk);
        check({tag, " end_line"}, int'(cur_line(which)), 1);
        check({tag, " end_busy"}, int'(cur_busy(which)), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        reset       = 1'b1;
        data_in     = '0;
        valid8      = 1'b0;
        valid7      = 1'b0;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst serial_out", int'(so8), 1);
        check("rst tx_busy", int'(busy8), 0);
        check("rst fifo_count", int'(count8), 0);
        check("rst ready", int'(ready8), 1);
        reset = 1'b0;
        @(negedge clk);
        check("idle serial_out", int'(so8), 1);

        // 0xA5, 8N1
        data_in = 8'hA5;
        valid8  = 1'b1;
        @(negedge clk);
        valid8 = 1'b0;
        check("a5 count_after_push", int'(count8), 1);
        check("a5 busy_before_pop", int'(busy8), 0);
        rx_frame("a5", 0, 16'h034A, 10, g);
        check("a5 pop_latency", g, 1);
        check("a5 count_end", int'(count8), 0);

        // 0x03 on the 7-bit instance, odd parity, two stop bits
        data_in     = 8'h03;
        parity_mode = 2'b10;
        two_stop    = 1'b1;
        valid7      = 1'b1;
        @(negedge clk);
        valid7 = 1'b0;
        rx_frame("b7o2", 1, 16'h0706, 11, g);
        check("b7o2 pop_latency", g, 1);
        parity_mode = 2'b00;
        two_stop    = 1'b0;

        // Six consecutive pushes into a 4-deep FIFO while idle
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    data_in = burst[k];
                    valid8  = 1'b1;
                    if (k == 5) begin
                        check("burst ready_full", int'(ready8), 0);
                        check("burst count_full", int'(count8), 4);
                    end
                    @(negedge clk);
                end
                valid8 = 1'b0;
                check("burst count_after_refuse", int'(count8), 4);
            end
            begin
                int gb;
                for (int k = 0; k < 5; k++) begin
                    rx_frame($sformatf("burst%0d", k), 0, {6'b0, 1'b1, burst[k], 1'b0}, 10, gb);
                    if (k > 0) check($sformatf("burst%0d gap", k), gb, 1);
                end
            end
        join
        check("burst count_drained", int'(count8), 0);

        // Simultaneous push/pop at count 2, write pointer wrap
        do_reset();
        fork
            begin
                int w;
                for (int k = 0; k < 3; k++) begin
                    data_in = wrap_bytes[k];
                    valid8  = 1'b1;
                    @(negedge clk);
                end
                valid8 = 1'b0;
                check("wrap count_queued", int'(count8), 2);
                w = 0;
                while (busy8 === 1'b1 && w < 300) begin
                    w++;
                    @(negedge clk);
                end
                check("wrap idle_reached", int'(w < 300), 1);
                check("wrap count_idle", int'(count8), 2);
                data_in = wrap_bytes[3];
                valid8  = 1'b1;
                @(negedge clk);
                check("wrap count_push_pop", int'(count8), 2);
                data_in = wrap_bytes[4];
                @(negedge clk);
                valid8 = 1'b0;
                check("wrap count_after_wrap", int'(count8), 3);
            end
            begin
                int gw;
                for (int k = 0; k < 5; k++) begin
                    rx_frame($sformatf("wrap%0d", k), 0, {6'b0, 1'b1, wrap_bytes[k], 1'b0}, 10, gw);
                    if (k > 0) check($sformatf("wrap%0d gap", k), gw, 1);
                end
            end
        join

        // Reset at cycle 35 of a frame with two bytes queued
        do_reset();
        data_in = 8'h00;
        valid8  = 1'b1;
        @(negedge clk);
        data_in = 8'hFF;
        @(negedge clk);
        data_in = 8'h55;
        @(negedge clk);
        valid8 = 1'b0;
        check("abort count_queued", int'(count8), 2);
        repeat (33) @(negedge clk);
        check("abort line_before", int'(so8), 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort serial_out", int'(so8), 1);
        check("abort tx_busy", int'(busy8), 0);
        check("abort fifo_count", int'(count8), 0);
        check("abort ready", int'(ready8), 1);
        reset = 1'b0;
        begin
            int lows, busys;
            lows  = 0;
            busys = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (so8 !== 1'b1) lows++;
                if (busy8 !== 1'b0) busys++;
            end
            check("abort no_frames_line", lows, 0);
            check("abort no_frames_busy", busys, 0);
        end

        // parity_mode 00 -> 01 during the first frame
        fork
            begin
                data_in = 8'h07;
                valid8  = 1'b1;
                @(negedge clk);
                @(negedge clk);
                valid8 = 1'b0;
                repeat (20) @(negedge clk);
                parity_mode = 2'b01;
            end
            begin
                int gp;
                rx_frame("pchg0", 0, 16'h020E, 10, gp);
                rx_frame("pchg1", 0, 16'h060E, 11, gp);
                check("pchg1 gap", gp, 1);
            end
        join
        parity_mode = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
